// File: rtl/data_ram_master_if.sv
// CPU-side load/store handshake of the data-RAM master.
// The CPU owns the master modport; data_ram_master uses the slave modport.
interface data_ram_master_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (output req, we, size, sign_ext, addr, wdata,
                    input  rdata, busy, done, err);
    modport slave  (input  req, we, size, sign_ext, addr, wdata,
                    output rdata, busy, done, err);
endinterface

// File: rtl/data_ram_master.sv
// Initiator for a big-endian, word-organised data RAM with a shared data bus.
// Sub-word stores are read-modify-write; sub-word loads are lane-extracted.
module data_ram_master (
    input  logic              CLK,
    input  logic              Reset,
    data_ram_master_if.slave  cpu,
    output logic [31:0]       ram_addr,
    output logic              ram_RW,
    inout  wire  [31:0]       ram_data
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        MERGE   = 3'd2,
        WSETUP  = 3'd3,
        WSTROBE = 3'd4,
        WHOLD   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] addr_r;
    logic [31:0] word_r;
    logic [31:0] rdata_r;
    logic [31:0] ram_addr_r;
    logic [31:0] addr_sel_s;
    logic [15:0] wdata_r;
    logic [1:0]  size_r;
    logic        we_r;
    logic        sext_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        ram_rw_r;
    logic        accept_s;
    logic        bad_s;

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] k,
                                                 input logic [1:0] size, input logic sext);
        logic [7:0]  b_v;
        logic [15:0] h_v;
        logic [31:0] res_v;
        b_v = word[(5'd31 - {k, 3'b000}) -: 8];
        h_v = word[(5'd31 - {k, 3'b000}) -: 16];
        case (size)
            2'b00:   res_v = {{24{sext & b_v[7]}}, b_v};
            2'b01:   res_v = {{16{sext & h_v[15]}}, h_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] d,
                                               input logic [1:0] k, input logic [1:0] size);
        logic [4:0]  sh_v;
        logic [31:0] mask_v;
        logic [31:0] ins_v;
        case (size)
            2'b00: begin
                sh_v   = 5'd24 - {k, 3'b000};
                mask_v = 32'h0000_00FF << sh_v;
                ins_v  = {24'h00_0000, d[7:0]} << sh_v;
            end
            2'b01: begin
                sh_v   = 5'd16 - {k, 3'b000};
                mask_v = 32'h0000_FFFF << sh_v;
                ins_v  = {16'h0000, d} << sh_v;
            end
            default: begin
                sh_v   = 5'd0;
                mask_v = 32'h0000_0000;
                ins_v  = 32'h0000_0000;
            end
        endcase
        return (word & ~mask_v) | ins_v;
    endfunction

    // Next-state logic, including request acceptance and the legality check.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        addr_sel_s = addr_r;
        bad_s      = (cpu.size == 2'b11) ||
                     ((cpu.size == 2'b01) && cpu.addr[0]) ||
                     ((cpu.size == 2'b10) && (cpu.addr[1:0] != 2'b00));
        case (state_r)
            IDLE: begin
                addr_sel_s = cpu.addr;
                if (cpu.req) begin
                    accept_s = 1'b1;
                    if (bad_s) begin
                        state_s = DONE;
                    end else if (cpu.we && (cpu.size == 2'b10)) begin
                        state_s = WSETUP;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (we_r) begin
                    state_s = MERGE;
                end else begin
                    state_s = DONE;
                end
            end
            MERGE:   state_s = WSETUP;
            WSETUP:  state_s = WSTROBE;
            WSTROBE: state_s = WHOLD;
            WHOLD:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture, RAM-side datapath and registered outputs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            addr_r     <= 32'h0000_0000;
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            sext_r     <= 1'b0;
            wdata_r    <= 16'h0000;
            word_r     <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
            ram_addr_r <= 32'h0000_0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            ram_rw_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r  <= cpu.addr;
                we_r    <= cpu.we;
                size_r  <= cpu.size;
                sext_r  <= cpu.sign_ext;
                wdata_r <= cpu.wdata[15:0];
            end
            // word_r carries the word store data, or the read word being merged.
            if (accept_s) begin
                word_r <= cpu.wdata;
            end else if (state_r == RD) begin
                word_r <= ram_data;
            end else if (state_r == MERGE) begin
                word_r <= lane_merge(word_r, wdata_r, addr_r[1:0], size_r);
            end
            if ((state_r == RD) && !we_r) begin
                rdata_r <= lane_extract(ram_data, addr_r[1:0], size_r, sext_r);
            end
            if ((state_s == RD) || (state_s == WSTROBE)) begin
                ram_addr_r <= {addr_sel_s[31:2], 2'b00};
            end
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == DONE);
            err_r    <= accept_s & bad_s;
            ram_rw_r <= (state_s == WSETUP) || (state_s == WSTROBE) || (state_s == WHOLD);
        end
    end

    assign cpu.rdata = rdata_r;
    assign cpu.busy  = busy_r;
    assign cpu.done  = done_r;
    assign cpu.err   = err_r;
    assign ram_addr  = ram_addr_r;
    assign ram_RW    = ram_rw_r;
    // Driver enable is the RW register itself, so bus turnaround happens on one edge.
    assign ram_data  = ram_rw_r ? word_r : 32'bz;
endmodule

// File: tb/tb_data_ram_master.sv
// Bench for data_ram_master: a 64-word RAM on the shared bus, a byte-level
// big-endian reference model, a directed vector table and randomized traffic.
module tb_data_ram_master;
    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] ram_addr;
    logic        ram_RW;
    wire  [31:0] ram_data;

    data_ram_master_if cpu_if ();

    data_ram_master dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .cpu      (cpu_if),
        .ram_addr (ram_addr),
        .ram_RW   (ram_RW),
        .ram_data (ram_data)
    );

    always #5 CLK = ~CLK;

    // RAM: drives the bus while RW=0, writes on edges where RW was already high.
    logic [31:0] mem [0:63];
    logic        rw_q = 1'b0;
    assign ram_data = ram_RW ? 32'bz : mem[ram_addr[7:2]];
    always @(posedge CLK) begin
        rw_q <= ram_RW;
        if (ram_RW && rw_q) mem[ram_addr[7:2]] <= ram_data;
    end

    logic [7:0]  ref_b [0:255];
    logic [31:0] exp_rdata;
    logic [31:0] exp_ram_addr;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        bit          we;
        bit [1:0]    size;
        bit          sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;
    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_err(input bit [1:0] size, input logic [31:0] a);
        return (size == 2'b11) || ((size == 2'b01) && a[0]) ||
               ((size == 2'b10) && (a[1:0] != 2'b00));
    endfunction

    function automatic int m_lat(input bit we, input bit [1:0] size, input bit er);
        if (er) return 1;
        if (!we) return 2;
        return (size == 2'b10) ? 4 : 6;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int b;
        b = int'(a[7:0]) & 252;
        return {ref_b[b], ref_b[b+1], ref_b[b+2], ref_b[b+3]};
    endfunction

    function automatic logic [31:0] m_load(input bit [1:0] size, input bit sext, input logic [31:0] a);
        int          b;
        logic [7:0]  v8;
        logic [15:0] v16;
        b = int'(a[7:0]);
        if (size == 2'b00) begin
            v8 = ref_b[b];
            return {{24{sext & v8[7]}}, v8};
        end else if (size == 2'b01) begin
            v16 = {ref_b[b], ref_b[b+1]};
            return {{16{sext & v16[15]}}, v16};
        end
        return m_word(a);
    endfunction

    task automatic m_store(input bit [1:0] size, input logic [31:0] a, input logic [31:0] d);
        int b;
        b = int'(a[7:0]);
        if (size == 2'b00) begin
            ref_b[b] = d[7:0];
        end else if (size == 2'b01) begin
            ref_b[b]   = d[15:8];
            ref_b[b+1] = d[7:0];
        end else begin
            ref_b[b]   = d[31:24];
            ref_b[b+1] = d[23:16];
            ref_b[b+2] = d[15:8];
            ref_b[b+3] = d[7:0];
        end
    endtask

    // One access: entered and left at posedge+1 of an IDLE cycle.
    task automatic do_op(input bit we, input bit [1:0] size, input bit sext, input logic [31:0] a,
                         input logic [31:0] wd, input bit noise,
                         output logic [31:0] rd, output bit er, output int lat, output logic [7:0] rws,
                         output bit busy_hi, output bit done_seen, output logic [31:0] ra,
                         output bit busy_after);
        cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.size = size; cpu_if.sign_ext = sext;
        cpu_if.addr = a; cpu_if.wdata = wd;
        @(posedge CLK);
        lat = 0; rws = 8'h00; busy_hi = 1'b1; done_seen = 1'b0;
        rd = 32'h0; er = 1'b0; ra = 32'h0;
        for (int i = 0; i < 16; i++) begin
            #1;
            lat++;
            rws = {rws[6:0], ram_RW};
            busy_hi = busy_hi & cpu_if.busy;
            if (cpu_if.done) begin
                done_seen = 1'b1; rd = cpu_if.rdata; er = cpu_if.err; ra = ram_addr;
                break;
            end
            if (noise) begin
                cpu_if.req = 1'($urandom_range(0, 1)); cpu_if.we = 1'($urandom_range(0, 1));
                cpu_if.size = 2'($urandom_range(0, 3)); cpu_if.addr = $urandom; cpu_if.wdata = $urandom;
            end else begin
                cpu_if.req = 1'b0;
            end
            @(posedge CLK);
        end
        cpu_if.req = 1'b0;
        @(posedge CLK);
        #1;
        busy_after = cpu_if.busy;
    endtask

    task automatic exec(input bit we, input bit [1:0] size, input bit sext, input logic [31:0] a,
                        input logic [31:0] wd, input bit noise,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
        logic [31:0] rd, ra;
        logic [7:0]  rws;
        bit          er, busy_hi, done_seen, busy_after;
        int          lat;
        do_op(we, size, sext, a, wd, noise, rd, er, lat, rws, busy_hi, done_seen, ra, busy_after);
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(er), 32'(exp_err));
        chk("rdata", rd, exp_rd);
        chk("ram_rw_seq", 32'(rws), (exp_err || !we) ? 32'h0 : 32'h0000_000E);
        chk("busy_during", 32'(busy_hi), 32'd1);
        chk("busy_after", 32'(busy_after), 32'd0);
        if (!exp_err) exp_ram_addr = {a[31:2], 2'b00};
        chk("ram_addr", ra, exp_ram_addr);
        if (we && !exp_err) begin
            m_store(size, a, wd);
            chk("ram_word", mem[a[7:2]], m_word(a));
        end
        if (!we && !exp_err) exp_rdata = exp_rd;
    endtask

    initial begin
        logic [31:0] a, wd, erd;
        bit          we, sx, er, noise;
        bit [1:0]    sz;

        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.size = 2'b00; cpu_if.sign_ext = 1'b0;
        cpu_if.addr = 32'h0; cpu_if.wdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
        exp_rdata = 32'h0; exp_ram_addr = 32'h0;

        Reset = 1'b1;
        #2 Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_flags", {28'h0, cpu_if.busy, cpu_if.done, cpu_if.err, ram_RW}, 32'h0);
        chk("reset_rdata", cpu_if.rdata, 32'h0);
        chk("reset_ram_addr", ram_addr, 32'h0);
        Reset = 1'b1;
        @(posedge CLK);
        #1;

        for (int w = 0; w < 64; w++) exec(1'b1, 2'b10, 1'b0, 32'(w * 4), 32'h0, 1'b0, exp_rdata, 1'b0, 4);

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 4};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
        tbl[2]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0, 4};
        tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 32'hDEAD_BEEF, 1'b0, 6};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'h1122_AA44, 1'b0, 2};
        tbl[5]  = '{1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF_7F01, 32'h1122_AA44, 1'b0, 4};
        tbl[6]  = '{1'b0, 2'b00, 1'b1, 32'h31, 32'h0,         32'hFFFF_FFFF, 1'b0, 2};
        tbl[7]  = '{1'b0, 2'b00, 1'b1, 32'h32, 32'h0,         32'h0000_007F, 1'b0, 2};
        tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h30, 32'h0,         32'h0000_80FF, 1'b0, 2};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0,         32'h0000_80FF, 1'b1, 1};
        tbl[10] = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0,         32'h0000_80FF, 1'b1, 1};
        tbl[11] = '{1'b1, 2'b11, 1'b0, 32'h14, 32'h1234_5678, 32'h0000_80FF, 1'b1, 1};
        tbl[12] = '{1'b0, 2'b01, 1'b1, 32'h32, 32'h0,         32'h0000_7F01, 1'b0, 2};
        tbl[13] = '{1'b0, 2'b01, 1'b1, 32'h30, 32'h0,         32'hFFFF_80FF, 1'b0, 2};
        tbl[14] = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, 32'hFFFF_80FF, 1'b0, 6};
        tbl[15] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEAD_1234, 1'b0, 2};
        tbl[16] = '{1'b0, 2'b00, 1'b0, 32'h33, 32'h0,         32'h0000_0001, 1'b0, 2};
        tbl[17] = '{1'b1, 2'b00, 1'b0, 32'h30, 32'h0000_00C3, 32'h0000_0001, 1'b0, 6};
        tbl[18] = '{1'b0, 2'b10, 1'b0, 32'h30, 32'h0,         32'hC3FF_7F01, 1'b0, 2};
        for (int i = 0; i < 19; i++)
            exec(tbl[i].we, tbl[i].size, tbl[i].sext, tbl[i].addr, tbl[i].wdata, i[0],
                 tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_lat);

        for (int n = 0; n < 150; n++) begin
            we    = 1'($urandom_range(0, 1));
            sz    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            sx    = 1'($urandom_range(0, 1));
            a     = 32'($urandom_range(0, 255));
            wd    = $urandom;
            noise = 1'($urandom_range(0, 1));
            er    = m_err(sz, a);
            erd   = (!we && !er) ? m_load(sz, sx, a) : exp_rdata;
            exec(we, sz, sx, a, wd, noise, erd, er, m_lat(we, sz, er));
        end

        // Reset asserted while a word store sits in WSTROBE.
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.size = 2'b10; cpu_if.addr = 32'h40;
        cpu_if.wdata = 32'hA5A5_A5A5;
        @(posedge CLK);
        #1 cpu_if.req = 1'b0;
        @(posedge CLK);
        #3 Reset = 1'b0;
        #1;
        chk("rst_busy", 32'(cpu_if.busy), 32'd0);
        chk("rst_flags", {29'h0, cpu_if.done, cpu_if.err, ram_RW}, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_rdata", cpu_if.rdata, 32'h0);
        chk("rst_bus_released", ram_data, mem[0]);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        for (int k = 0; k < 4; k++) ref_b[64 + k] = mem[16][31 - 8 * k -: 8];
        exp_rdata = 32'h0; exp_ram_addr = 32'h0;
        exec(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, m_word(32'h40), 1'b0, 2);
        exec(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 1'b1, m_load(2'b00, 1'b1, 32'h31), 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
